// File: rtl/cacheline_mem_arbiter_if.sv
// rtl/cacheline_mem_arbiter_if.sv - cache/memory bus bundle for the cacheline memory arbiter
interface cacheline_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_addr;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic              busy;
  logic [CNT_W-1:0]  i_grants;
  logic [CNT_W-1:0]  d_grants;

  // Arbiter view
  modport slave (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    output i_resp, d_resp, rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata,
           busy, i_grants, d_grants
  );

  // Caches-plus-memory view
  modport master (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
    input  i_resp, d_resp, rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata,
           busy, i_grants, d_grants
  );
endinterface

// File: rtl/cacheline_mem_arbiter.sv
// rtl/cacheline_mem_arbiter.sv - shares one cacheline memory port between I-cache and D-cache
module cacheline_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  cacheline_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_last_d;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_i_grants;
  logic [CNT_W-1:0]  r_d_grants;

  logic w_i_req;
  logic w_d_req;
  logic w_contend;
  logic w_grant_i;
  logic w_grant_d;

  assign w_i_req   = bus.i_read;
  assign w_d_req   = bus.d_read | bus.d_write;
  assign w_contend = w_i_req & w_d_req;

  // State register; reset abandons any in-flight memory transaction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Arbitration, next state, and strobes driven only from the latched command
  always_comb begin
    w_next_state   = r_state;
    w_grant_i      = 1'b0;
    w_grant_d      = 1'b0;
    bus.i_resp     = 1'b0;
    bus.d_resp     = 1'b0;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr  = '0;
    bus.pmem_wdata = '0;
    case (r_state)
      IDLE: begin
        // On contention the side that did not win the previous contention goes first
        if (w_contend) begin
          w_grant_i = r_last_d;
          w_grant_d = ~r_last_d;
        end else begin
          w_grant_i = w_i_req;
          w_grant_d = w_d_req;
        end
        if (w_grant_i) begin
          w_next_state = SERVE_I;
        end else if (w_grant_d) begin
          w_next_state = SERVE_D;
        end
      end
      SERVE_I: begin
        bus.pmem_read  = ~r_wr;
        bus.pmem_write = r_wr;
        bus.pmem_addr  = r_addr;
        bus.pmem_wdata = r_wdata;
        if (bus.pmem_resp) begin
          bus.i_resp   = 1'b1;
          w_next_state = DONE;
        end
      end
      SERVE_D: begin
        bus.pmem_read  = ~r_wr;
        bus.pmem_write = r_wr;
        bus.pmem_addr  = r_addr;
        bus.pmem_wdata = r_wdata;
        if (bus.pmem_resp) begin
          bus.d_resp   = 1'b1;
          w_next_state = DONE;
        end
      end
      // One dead cycle so the cache's held-over request is not granted again
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Command latch, contention history and saturating grant counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_d   <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_i_grants <= '0;
      r_d_grants <= '0;
    end else begin
      if (w_grant_i) begin
        r_addr  <= bus.i_addr;
        r_wr    <= 1'b0;
        r_wdata <= '0;
        if (r_i_grants != '1) begin
          r_i_grants <= r_i_grants + CNT_W'(1);
        end
      end
      if (w_grant_d) begin
        r_addr  <= bus.d_addr;
        r_wr    <= bus.d_write;
        r_wdata <= bus.d_wdata;
        if (r_d_grants != '1) begin
          r_d_grants <= r_d_grants + CNT_W'(1);
        end
      end
      if (w_contend && (w_grant_i || w_grant_d)) begin
        r_last_d <= w_grant_d;
      end
    end
  end

  assign bus.rdata    = bus.pmem_rdata;
  assign bus.busy     = (r_state != IDLE);
  assign bus.i_grants = r_i_grants;
  assign bus.d_grants = r_d_grants;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb/tb_cacheline_mem_arbiter.sv - scoreboard bench for cacheline_mem_arbiter
module tb_cacheline_mem_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) bus ();

  cacheline_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } req_t;

  req_t iq[$];
  req_t dq[$];
  int   checks   = 0;
  int   failures = 0;
  bit   end_flag = 1'b0;

  function automatic logic [LINE_W-1:0] line_of(logic [ADDR_W-1:0] a);
    return {8{(a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3}};
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(string name, logic [LINE_W-1:0] act, logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- stimulus: two cache models plus a memory model ----------------
  int i_st = 0;        // 0 idle, 1 requesting, 2 holding one cycle after resp
  int d_st = 0;
  bit i_resp_s, d_resp_s;
  int fixed_lat = -1;
  bit mem_hold  = 1'b0;
  bit rand_en   = 1'b0;
  int pulse_pct = 0;
  int mem_wait  = 0;

  task automatic issue_i(logic [ADDR_W-1:0] a);
    bus.i_read = 1'b1;
    bus.i_addr = a;
    iq.push_back('{wr: 1'b0, addr: a, wdata: '0});
    i_st = 1;
  endtask

  task automatic issue_d(logic rd, logic wr, logic [ADDR_W-1:0] a, logic [LINE_W-1:0] wd);
    bus.d_read  = rd;
    bus.d_write = wr;
    bus.d_addr  = a;
    bus.d_wdata = wd;
    dq.push_back('{wr: wr, addr: a, wdata: wd});
    d_st = 1;
  endtask

  task automatic step();
    int k;
    @(negedge clk);
    i_resp_s = bus.i_resp;
    d_resp_s = bus.d_resp;
    @(posedge clk);
    #1;
    if (!rst) begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
    end else if (bus.pmem_resp) begin
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = rand_line();
    end else if (bus.pmem_read || bus.pmem_write) begin
      if (!mem_hold) begin
        if (mem_wait == 0) begin
          bus.pmem_resp  = 1'b1;
          bus.pmem_rdata = line_of(bus.pmem_addr);
        end else begin
          mem_wait--;
        end
      end
    end else begin
      mem_wait = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
      bus.pmem_rdata = rand_line();
      if (int'($urandom_range(0, 99)) < pulse_pct) bus.pmem_resp = 1'b1;
    end
    if (i_st == 2) begin
      bus.i_read = 1'b0;
      i_st = 0;
    end else if (i_st == 1 && i_resp_s) begin
      i_st = 2;
    end
    if (d_st == 2) begin
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      d_st = 0;
    end else if (d_st == 1 && d_resp_s) begin
      d_st = 2;
    end
    if (rand_en && rst) begin
      if (i_st == 0 && $urandom_range(0, 99) < 40) issue_i($urandom & 32'hFFFF_FFE0);
      if (d_st == 0 && $urandom_range(0, 99) < 40) begin
        k = int'($urandom_range(0, 2));
        issue_d(k != 1, k != 0, $urandom & 32'hFFFF_FFE0, rand_line());
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = '0;
    i_st = 0;
    d_st = 0;
    iq.delete();
    dq.delete();
    step();
    rst = 1'b1;
  endtask

  initial begin
    bus.i_read = 1'b0;  bus.i_addr = '0;
    bus.d_read = 1'b0;  bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.pmem_resp = 1'b0; bus.pmem_rdata = '0;
    repeat (3) step();
    rst = 1'b1;
    step();
    // Single I read, five-cycle memory latency
    fixed_lat = 4;
    issue_i(32'h0000_1000);
    repeat (12) step();
    // Contention straight after reset, both sides keep requesting
    do_reset();
    fixed_lat = 1;
    issue_i(32'h0000_3000);
    issue_d(1'b0, 1'b1, 32'h0000_4000, rand_line());
    for (int c = 0; c < 45; c++) begin
      step();
      if (c < 30) begin
        if (i_st == 0) issue_i(32'h0000_3000 + 32'(c) * 32'h20);
        if (d_st == 0) issue_d(1'b1, 1'b0, 32'h0000_5000 + 32'(c) * 32'h20, rand_line());
      end
    end
    // Inputs change under an I transaction; D arrives mid-flight
    fixed_lat = 4;
    issue_i(32'h0000_1000);
    repeat (2) step();
    bus.i_addr = 32'h0000_2000;
    issue_d(1'b1, 1'b0, 32'h0000_6000, rand_line());
    repeat (20) step();
    // Read and write together: write wins
    issue_d(1'b1, 1'b1, 32'h0000_7000, rand_line());
    repeat (10) step();
    // Reset in the middle of a D transaction, then contention
    mem_hold = 1'b1;
    issue_d(1'b1, 1'b0, 32'h0000_8000, rand_line());
    repeat (4) step();
    do_reset();
    mem_hold = 1'b0;
    fixed_lat = 2;
    issue_i(32'h0000_9000);
    issue_d(1'b1, 1'b0, 32'h0000_A000, rand_line());
    repeat (20) step();
    // Randomised traffic, spurious idle responses, counters run into saturation
    fixed_lat = -1;
    pulse_pct = 10;
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    pulse_pct = 0;
    repeat (60) step();
    end_flag = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL end_of_run monitor did not finish");
    $fatal(1);
  end

  // ---------------- monitor: transaction-level reference and scoreboard ----------------
  int               ph = 0;     // 0 idle, 1 serving, 2 dead cycle after resp
  bit               last_d = 1'b0;
  int               own = 0;    // 0 = I, 1 = D
  logic [CNT_W-1:0] ci = '0;
  logic [CNT_W-1:0] cd = '0;
  req_t             cur;
  bit               wi, wd;

  always @(negedge clk) begin
    if (end_flag) begin
      chk("i_queue_drained", iq.size() == 0, 1'b1);
      chk("d_queue_drained", dq.size() == 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end else if (!rst) begin
      chk("rst_i_resp", bus.i_resp, 1'b0);
      chk("rst_d_resp", bus.d_resp, 1'b0);
      chk("rst_pmem_read", bus.pmem_read, 1'b0);
      chk("rst_pmem_write", bus.pmem_write, 1'b0);
      chk("rst_pmem_addr", bus.pmem_addr, '0);
      chk("rst_pmem_wdata", bus.pmem_wdata, '0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_i_grants", bus.i_grants, '0);
      chk("rst_d_grants", bus.d_grants, '0);
      ph = 0;
      last_d = 1'b0;
      ci = '0;
      cd = '0;
    end else begin
      chk("rdata_broadcast", bus.rdata, bus.pmem_rdata);
      case (ph)
        0: begin
          chk("idle_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
          chk("idle_resps", {bus.i_resp, bus.d_resp}, 2'b00);
          chk("idle_busy", bus.busy, 1'b0);
          wi = bus.i_read;
          wd = bus.d_read | bus.d_write;
          if (wi || wd) begin
            if (wi && wd) begin
              own = last_d ? 0 : 1;
              last_d = (own == 1);
            end else begin
              own = wd ? 1 : 0;
            end
            if (own == 0) begin
              if (ci != CNT_MAX) ci = ci + 1'b1;
            end else begin
              if (cd != CNT_MAX) cd = cd + 1'b1;
            end
            ph = 1;
          end
        end
        1: begin
          chk("owner_queue_nonempty", (own == 0) ? (iq.size() != 0) : (dq.size() != 0), 1'b1);
          if ((own == 0 && iq.size() == 0) || (own == 1 && dq.size() == 0)) begin
            ph = 0;
          end else begin
            cur = (own == 0) ? iq[0] : dq[0];
            chk(own == 0 ? "i_pmem_read" : "d_pmem_read", bus.pmem_read, !cur.wr);
            chk(own == 0 ? "i_pmem_write" : "d_pmem_write", bus.pmem_write, cur.wr);
            chk(own == 0 ? "i_pmem_addr" : "d_pmem_addr", bus.pmem_addr, cur.addr);
            if (cur.wr) chk("d_pmem_wdata", bus.pmem_wdata, cur.wdata);
            chk("serve_busy", bus.busy, 1'b1);
            chk("i_grants", bus.i_grants, ci);
            chk("d_grants", bus.d_grants, cd);
            if (bus.pmem_resp) begin
              chk("i_resp", bus.i_resp, own == 0);
              chk("d_resp", bus.d_resp, own == 1);
              if (!cur.wr) chk("read_line", bus.rdata, line_of(cur.addr));
              if (own == 0) void'(iq.pop_front());
              else          void'(dq.pop_front());
              ph = 2;
            end else begin
              chk("serve_no_resp", {bus.i_resp, bus.d_resp}, 2'b00);
            end
          end
        end
        default: begin
          chk("done_strobes", {bus.pmem_read, bus.pmem_write}, 2'b00);
          chk("done_resps", {bus.i_resp, bus.d_resp}, 2'b00);
          chk("done_busy", bus.busy, 1'b1);
          ph = 0;
        end
      endcase
    end
  end
endmodule
